// File: rtl/sramc_ahb_arbiter.sv
// rtl/sramc_ahb_arbiter.sv - two-requester req/ack front end onto the sramc_top AHB-lite slave port (optional SRAMC_ARB_FIXED_PRIO_EN)
module sramc_ahb_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [2:0]    size0,
    input  logic [2:0]    size1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          hsel,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [AW-1:0] haddr,
    output logic [DW-1:0] hwdata,
    output logic          hready,
    input  logic [DW-1:0] hrdata,
    input  logic          hready_resp,
    input  logic [1:0]    hresp
);

    localparam logic [2:0] SIZE_MAX   = 3'($clog2(DW / 8));
    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ACK
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            any_req;
    logic            grant_id;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [2:0]      sel_size;
    logic [DW-1:0]   sel_wdata;
    logic            bad_req;

    logic            cur_id;
    logic [DW-1:0]   cur_wdata;
    logic            err_flag;
    logic            resp_err;

`ifndef SRAMC_ARB_FIXED_PRIO_EN
    logic            last_grant;
`endif

    assign hready   = hready_resp;
    assign resp_err = (hresp != RESP_OKAY);

    // Pick the grantee and pre-qualify its request (size and alignment)
    always_comb begin
        any_req = req0 | req1;
`ifdef SRAMC_ARB_FIXED_PRIO_EN
        grant_id = ~req0;
`else
        grant_id = (req0 && req1) ? ~last_grant : req1;
`endif
        sel_we    = grant_id ? we1    : we0;
        sel_addr  = grant_id ? addr1  : addr0;
        sel_size  = grant_id ? size1  : size0;
        sel_wdata = grant_id ? wdata1 : wdata0;
        bad_req   = (sel_size > SIZE_MAX)
                  || ((sel_size == 3'd1) && sel_addr[0])
                  || ((sel_size == 3'd2) && (sel_addr[1:0] != 2'b00));
    end

`ifndef SRAMC_ARB_FIXED_PRIO_EN
    // Remember who was served last so simultaneous requests alternate
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            last_grant <= 1'b1;
        end else if (state == ST_IDLE && any_req) begin
            last_grant <= grant_id;
        end
    end
`endif

    // State register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: illegal requests skip the bus and complete straight away
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = bad_req ? ST_ACK : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hready_resp) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hready_resp) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered bus and requester outputs, updated on state transitions
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hsel      <= 1'b0;
            htrans    <= TR_IDLE;
            hwrite    <= 1'b0;
            hsize     <= 3'd0;
            haddr     <= '0;
            hwdata    <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            cur_id    <= 1'b0;
            cur_wdata <= '0;
            err_flag  <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        cur_id    <= grant_id;
                        cur_wdata <= sel_wdata;
                        err_flag  <= 1'b0;
                        if (bad_req) begin
                            if (grant_id) begin
                                ack1 <= 1'b1;
                                err1 <= 1'b1;
                            end else begin
                                ack0 <= 1'b1;
                                err0 <= 1'b1;
                            end
                        end else begin
                            hsel   <= 1'b1;
                            htrans <= TR_NONSEQ;
                            hwrite <= sel_we;
                            hsize  <= sel_size;
                            haddr  <= sel_addr;
                        end
                    end
                end
                ST_ADDR: begin
                    if (hready_resp) begin
                        hsel   <= 1'b0;
                        htrans <= TR_IDLE;
                        if (hwrite) begin
                            hwdata <= cur_wdata;
                        end
                    end
                end
                ST_DATA: begin
                    // Sticky so the first cycle of a two-cycle ERROR is not lost
                    if (resp_err) begin
                        err_flag <= 1'b1;
                    end
                    if (hready_resp) begin
                        if (cur_id) begin
                            ack1 <= 1'b1;
                            err1 <= err_flag | resp_err;
                            if (!hwrite) begin
                                rdata1 <= hrdata;
                            end
                        end else begin
                            ack0 <= 1'b1;
                            err0 <= err_flag | resp_err;
                            if (!hwrite) begin
                                rdata0 <= hrdata;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sramc_ahb_arbiter.sv
// tb/tb_sramc_ahb_arbiter.sv - self-checking bench for sramc_ahb_arbiter
module tb_sramc_ahb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [2:0]    size0, size1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          hsel, hwrite, hready;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready_resp;
    logic [1:0]    hresp;

    int total = 0;
    int bad   = 0;

    sramc_ahb_arbiter #(.AW(AW), .DW(DW)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .size0(size0), .size1(size1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .hsel(hsel), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .haddr(haddr), .hwdata(hwdata), .hready(hready),
        .hrdata(hrdata), .hready_resp(hready_resp), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave: word memory, errors in region 0xF00-0xFFF ----------------
    function automatic logic [31:0] dflt(input logic [9:0] k);
        return {6'h2A, k, 16'hC35A};
    endfunction

    logic        dphase, d_write, d_err;
    logic [9:0]  d_key;
    logic [31:0] smem [0:1023];
    logic        swr  [0:1023];
    int          acc_cnt = 0;

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dphase  <= 1'b0;
            d_write <= 1'b0;
            d_err   <= 1'b0;
            d_key   <= '0;
            for (int i = 0; i < 1024; i++) swr[i] <= 1'b0;
        end else begin
            if (dphase && hready_resp) begin
                dphase <= 1'b0;
                if (d_write && !d_err) begin
                    smem[d_key] <= hwdata;
                    swr[d_key]  <= 1'b1;
                end
            end
            if (hsel && htrans == 2'b10 && hready_resp) begin
                dphase  <= 1'b1;
                d_write <= hwrite;
                d_key   <= haddr[11:2];
                d_err   <= (haddr[11:8] == 4'hF);
                acc_cnt <= acc_cnt + 1;
            end
        end
    end

    assign hrdata = swr[d_key] ? smem[d_key] : dflt(d_key);
    assign hresp  = (dphase && d_err) ? 2'b01 : 2'b00;

    // ---------------- hready_resp driver: scripted, random or always ready ----------------
    bit        hr_q [$];
    bit [15:0] hr_pat;
    int        hr_len = 0;
    bit        rand_mode = 1'b0;

    initial begin
        hready_resp = 1'b1;
        forever begin
            @(posedge hclk);
            #1;
            if (hr_q.size() > 0) hready_resp = hr_q.pop_front();
            else if (rand_mode) hready_resp = ($urandom_range(0, 3) != 0);
            else hready_resp = 1'b1;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mref   [0:1023];
    bit          mvalid [0:1023];
    int          exp_bus = 0;

    function automatic bit local_bad(input logic [31:0] a, input logic [2:0] s);
        int sz = int'(s);
        if (sz > 2) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) mvalid[i] = 1'b0;
    endtask

    task automatic model_check(input string tag, input logic we, input logic [31:0] a,
                               input logic [2:0] s, input logic [31:0] d,
                               input logic [31:0] rd, input logic er);
        bit         e = local_bad(a, s) || (a[11:8] == 4'hF);
        logic [9:0] k = a[11:2];
        check_val({tag, "_err"}, er, e);
        if (!e) begin
            if (we) begin
                mref[k]   = d;
                mvalid[k] = 1'b1;
            end else begin
                check_val({tag, "_rdata"}, rd, mvalid[k] ? mref[k] : dflt(k));
            end
        end
    endtask

    // ---------------- requester helpers ----------------
    task automatic set_req(input int id, input logic r, input logic we, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] d);
        if (id == 0) begin
            req0 = r; we0 = we; addr0 = a; size0 = s; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; size1 = s; wdata1 = d;
        end
    endtask

    int          x_lat, x_taddr, x_naddr, x_stab;
    logic [31:0] x_rdata, x_hwdata;
    logic        x_err, x_other, x_hsel;

    // One directed transfer; cycle 0 is the IDLE cycle in which req is first seen
    task automatic xfer(input int id, input logic we, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] d);
        int cyc  = 0;
        bit done = 1'b0;
        @(negedge hclk);
        for (int i = 0; i < hr_len; i++) hr_q.push_back(hr_pat[i]);
        hr_len  = 0;
        x_lat   = -1; x_taddr = -1; x_naddr = 0; x_stab = 0;
        x_other = 1'b0; x_hsel = 1'b0; x_hwdata = '0; x_rdata = '0; x_err = 1'b0;
        set_req(id, 1'b1, we, a, s, d);
        while (!done && cyc < 60) begin
            @(negedge hclk);
            cyc++;
            if (hsel) x_hsel = 1'b1;
            if (hsel && htrans == 2'b10) begin
                if (x_taddr < 0) x_taddr = cyc;
                x_naddr++;
                if (haddr !== a || hwrite !== we || hsize !== s) x_stab++;
            end
            if ((id == 0) ? ack1 : ack0) x_other = 1'b1;
            if ((id == 0) ? ack0 : ack1) begin
                done    = 1'b1;
                x_lat   = cyc;
                x_rdata = (id == 0) ? rdata0 : rdata1;
                x_err   = (id == 0) ? err0 : err1;
                set_req(id, 1'b0, we, a, s, d);
            end else begin
                x_hwdata = hwdata;
            end
        end
        if (!done) begin
            check_val("xfer_timeout", 0, 1);
            set_req(id, 1'b0, we, a, s, d);
        end
        model_check("dir", we, a, s, d, x_rdata, x_err);
    endtask

    task automatic apply_reset();
        @(negedge hclk);
        hresetn = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        hr_q.delete();
        model_clear();
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
    endtask

    task automatic rand_req(input int id);
        for (int n = 0; n < 60; n++) begin
            int          gap = $urandom_range(0, 3);
            int          cyc = 0;
            bit          done = 1'b0;
            logic        we = 1'(($urandom_range(0, 1)));
            logic [3:0]  region = ($urandom_range(0, 7) == 0) ? 4'hF : 4'h0;
            logic [31:0] off = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
            logic [31:0] a = (32'(region) << 8) | (32'($urandom_range(0, 7)) << 2) | off;
            int          pick = $urandom_range(0, 9);
            logic [2:0]  s = (pick < 6) ? 3'd2 : (pick == 6) ? 3'd1 : (pick == 7) ? 3'd0 :
                             (pick == 8) ? 3'd3 : 3'($urandom_range(4, 7));
            logic [31:0] d = $urandom;
            repeat (gap + 1) @(negedge hclk);
            if (!local_bad(a, s)) exp_bus++;
            set_req(id, 1'b1, we, a, s, d);
            while (!done && cyc < 300) begin
                @(negedge hclk);
                cyc++;
                if ((id == 0) ? ack0 : ack1) begin
                    done = 1'b1;
                    model_check((id == 0) ? "rnd0" : "rnd1", we, a, s, d,
                                (id == 0) ? rdata0 : rdata1, (id == 0) ? err0 : err1);
                    set_req(id, 1'b0, we, a, s, d);
                end
            end
            if (!done) begin
                check_val("rand_timeout", 0, 1);
                set_req(id, 1'b0, we, a, s, d);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        int order [$];
        int cyc;
        int acc0;
        bit rearm0, rearm1, ack_seen;

        hresetn = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, 3'd0, '0);
        set_req(1, 1'b0, 1'b0, '0, 3'd0, '0);
        model_clear();
        repeat (2) @(negedge hclk);

        check_val("rst_hsel",   hsel,   0);
        check_val("rst_htrans", htrans, 0);
        check_val("rst_hwrite", hwrite, 0);
        check_val("rst_hsize",  hsize,  0);
        check_val("rst_haddr",  haddr,  0);
        check_val("rst_hwdata", hwdata, 0);
        check_val("rst_ack0",   ack0,   0);
        check_val("rst_ack1",   ack1,   0);
        check_val("rst_err0",   err0,   0);
        check_val("rst_err1",   err1,   0);
        check_val("rst_rdata0", rdata0, 0);
        check_val("rst_rdata1", rdata1, 0);
        hresetn = 1'b1;

        // zero-wait write then read back
        xfer(0, 1'b1, 32'h10, 3'd2, 32'hA5A5_1234);
        check_val("zw_taddr",  x_taddr,  1);
        check_val("zw_naddr",  x_naddr,  1);
        check_val("zw_hwdata", x_hwdata, 32'hA5A5_1234);
        check_val("zw_lat",    x_lat,    3);
        check_val("zw_other",  x_other,  0);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
        check_val("rd_lat",   x_lat,   3);
        check_val("rd_rdata", x_rdata, 32'hA5A5_1234);
        check_val("rd_err",   x_err,   0);

        // 2 wait states in ADDR, 3 in DATA
        acc0   = acc_cnt;
        hr_pat = 16'b0100_0100;
        hr_len = 7;
        xfer(0, 1'b1, 32'h20, 3'd2, 32'h1357_9BDF);
        check_val("ws_lat",   x_lat,   8);
        check_val("ws_taddr", x_taddr, 1);
        check_val("ws_naddr", x_naddr, 3);
        check_val("ws_stab",  x_stab,  0);
        check_val("ws_acc",   acc_cnt - acc0, 1);

        // misaligned word request from requester 1
        xfer(1, 1'b0, 32'h02, 3'd2, 32'h0);
        check_val("mis_lat",  x_lat,  1);
        check_val("mis_err",  x_err,  1);
        check_val("mis_hsel", x_hsel, 0);

        // two-cycle ERROR response from the slave
        hr_pat = 16'b101;
        hr_len = 3;
        xfer(0, 1'b0, 32'hF00, 3'd2, 32'h0);
        check_val("er_lat", x_lat, 4);
        check_val("er_err", x_err, 1);

        // both requesters keep asking; four grants in a row
        apply_reset();
        @(negedge hclk);
        set_req(0, 1'b1, 1'b0, 32'h100, 3'd2, '0);
        set_req(1, 1'b1, 1'b0, 32'h104, 3'd2, '0);
        cyc = 0; rearm0 = 1'b0; rearm1 = 1'b0;
        while (order.size() < 4 && cyc < 200) begin
            @(negedge hclk);
            cyc++;
            if (rearm0) begin req0 = 1'b1; rearm0 = 1'b0; end
            if (rearm1) begin req1 = 1'b1; rearm1 = 1'b0; end
            if (ack0) begin order.push_back(0); req0 = 1'b0; rearm0 = 1'b1; end
            if (ack1) begin order.push_back(1); req1 = 1'b0; rearm1 = 1'b1; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef SRAMC_ARB_FIXED_PRIO_EN
            check_val("arb_order", (i < order.size()) ? order[i] : 9, 0);
`else
            check_val("arb_order", (i < order.size()) ? order[i] : 9, i % 2);
`endif
        end
        repeat (3) @(negedge hclk);

        // reset pulsed during the data phase of a write
        @(negedge hclk);
        set_req(0, 1'b1, 1'b1, 32'h40, 3'd2, 32'hDEAD_BEEF);
        hr_q.push_back(1'b1);
        for (int i = 0; i < 5; i++) hr_q.push_back(1'b0);
        repeat (2) @(negedge hclk);
        check_val("mid_hwdata_pre", hwdata, 32'hDEAD_BEEF);
        hresetn = 1'b0;
        #1;
        check_val("mid_hsel",   hsel,   0);
        check_val("mid_htrans", htrans, 0);
        check_val("mid_haddr",  haddr,  0);
        check_val("mid_hwdata", hwdata, 0);
        check_val("mid_hwrite", hwrite, 0);
        set_req(0, 1'b0, 1'b0, '0, 3'd0, '0);
        hr_q.delete();
        model_clear();
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge hclk);
            ack_seen |= ack0 | ack1;
        end
        hresetn = 1'b1;
        repeat (2) begin
            @(negedge hclk);
            ack_seen |= ack0 | ack1;
        end
        check_val("mid_noack", ack_seen, 0);
        xfer(1, 1'b0, 32'h40, 3'd2, 32'h0);
        check_val("post_lat", x_lat, 3);

        // randomized concurrent traffic with random wait states
        acc0      = acc_cnt;
        exp_bus   = 0;
        rand_mode = 1'b1;
        fork
            rand_req(0);
            rand_req(1);
        join
        rand_mode = 1'b0;
        repeat (4) @(negedge hclk);
        check_val("bus_count", acc_cnt - acc0, exp_bus);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sramc_ahb_arbiter.md
Name: sramc_ahb_arbiter

Overview:
- Two-requester front end that shares the single AHB-lite slave port of the SRAM controller (sramc_top).
- Each requester uses a simple req/ack handshake. The block arbitrates between them, runs one AHB single transfer (NONSEQ, no burst) and returns read data or an error status.
- Sits between on-chip masters and sramc_top. It drives hsel/htrans/hwrite/hsize/haddr/hwdata/hready and samples hrdata/hready_resp/hresp.

Parameters:
- AW, 32, width of haddr and requester address.
- DW, 32, width of data buses. Maximum legal size is log2(DW/8).

Ports:
- hclk  input  1  single clock, all logic on rising edge.
- hresetn  input  1  asynchronous active-low reset.
- req0 / req1  input  1  transfer request, held until ack.
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  AW  byte address.
- size0 / size1  input  3  AHB hsize encoding.
- wdata0 / wdata1  input  DW  write data.
- ack0 / ack1  output  1  one-cycle completion pulse.
- rdata0 / rdata1  output  DW  read data, valid while ack is high.
- err0 / err1  output  1  error status, valid while ack is high.
- hsel  output  1  slave select.
- htrans  output  2  00 IDLE, 10 NONSEQ only.
- hwrite  output  1  transfer direction.
- hsize  output  3  transfer size.
- haddr  output  AW  transfer address.
- hwdata  output  DW  write data, data phase.
- hready  output  1  combinational copy of hready_resp.
- hrdata  input  DW  slave read data.
- hready_resp  input  1  slave ready.
- hresp  input  2  00 OKAY, anything else = error.

Behaviour:
- Reset (async, hresetn=0): state=IDLE; hsel=0, htrans=00, hwrite=0, hsize=0, haddr=0, hwdata=0; ack*=0, err*=0, rdata*=0; last_grant=1, so req0 wins first.
- All outputs except hready are registered.
- FSM states: IDLE, ADDR, DATA, ACK.
- IDLE:
  - No req: stay in IDLE, bus stays IDLE.
  - One req: grant it.
  - Both req: grant the requester that was not last_grant. Update last_grant.
  - Latch we/addr/size/wdata of the grantee.
  - If size > log2(DW/8), or addr is misaligned (size=1 with addr[0]=1, or size=2 with addr[1:0]≠0): go to ACK with err=1 and issue no bus transfer.
  - Otherwise go to ADDR.
- ADDR (address phase visible): hsel=1, htrans=10, latched hwrite/hsize/haddr.
  - hready_resp=1: go to DATA. On that edge hsel←0, htrans←00, hwdata←latched wdata (writes).
  - hready_resp=0: hold all address-phase outputs unchanged.
- DATA: wait for hready_resp=1.
  - An error flag is set if hresp≠00 in any DATA cycle, so both cycles of a two-cycle ERROR response are covered.
  - On completion: rdataN←hrdata (reads; writes leave rdata unchanged); errN←error flag. Go to ACK.
- ACK: ackN=1 for exactly one cycle, then IDLE. The other requester's ack stays 0.
- Requester protocol:
  - Hold req and all request fields stable from assertion until the ack cycle.
  - Drop req in the ack cycle, or it is taken as a new request in the next IDLE.
- Latency with zero wait states: req seen in IDLE at cycle 0; ADDR at cycle 1; DATA at cycle 2; ack at cycle 3. Each wait state adds one cycle.
- Misaligned or oversize request: ack with err=1 at cycle 1.
- The non-granted requester waits and is served in the next IDLE. No starvation under round-robin.
- Reset mid-transfer: the transfer is abandoned, the bus returns to IDLE, no ack is issued. Requesters re-issue after reset.
- hburst is not driven by this block; tie it to 0 at the integration level.

Optional Feature:
- SRAMC_ARB_FIXED_PRIO_EN.
- Defined: req0 always wins when both requesters are active in IDLE; last_grant is unused.
- Not defined: round-robin as above.

Test Plan:
- Zero-wait write then read: req0 we=1 addr=0x10 size=2 wdata=0xA5A5_1234 → htrans=10 on cycle 1, hwdata=0xA5A5_1234 on cycle 2, ack0 on cycle 3. A following req0 read of 0x10 → rdata0=0xA5A5_1234, err0=0.
- Simultaneous req0/req1 repeated 4 times after reset → grant order 0,1,0,1. With SRAMC_ARB_FIXED_PRIO_EN: 0,0,0,0 while req0 stays active.
- hready_resp=0 for 2 cycles in ADDR and 3 cycles in DATA → address phase held stable, ack at cycle 8, no duplicate htrans=10.
- Misaligned req1 addr=0x02 size=2 → ack1 with err1=1 at cycle 1, hsel stays 0.
- Slave two-cycle ERROR response (hresp=01 with hready_resp 0 then 1) → ack0 with err0=1.
- hresetn pulsed low during DATA → all outputs return to reset values immediately, no ack. A request issued after reset completes normally.
